// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the multi-cycle control unit.
//   state_e  - FSM state encoding, also driven out on STATE
//   OPC_*    - RV32I major opcodes accepted by the decoder
//   IMM_*    - immediate format codes driven on IMM_TYPE
//   ALU_*    - ALU operation codes driven on ALU_OPT
//   dec_t    - bundle of decoded instruction controls
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       has_rd;
        logic [3:0] alu_opt;
        logic [2:0] imm_type;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

    // ALU code is the alternate-op bit (funct7[5]) above funct3.
    function automatic logic [3:0] alu_code(input logic alt, input logic [2:0] funct3);
        return {alt, funct3};
    endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode/funct decode of the instruction register.
//   ir_i  - latched instruction word
//   dec_o - register fields, funct3, immediate format, ALU code,
//           load/store/rd-writing class and opcode legality
module cu_decode
    import cu_pkg::*;
(
    input  logic [31:0] ir_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_ir;

    assign opcode    = ir_i[6:0];
    assign funct3    = ir_i[14:12];
    assign unused_ir = ^{ir_i[31], ir_i[29:25]};

    always_comb begin
        dec_o          = '0;
        dec_o.rs1      = ir_i[19:15];
        dec_o.rs2      = ir_i[24:20];
        dec_o.rd       = ir_i[11:7];
        dec_o.funct3   = funct3;
        dec_o.alu_opt  = ALU_ADD;
        dec_o.legal    = 1'b1;
        dec_o.has_rd   = 1'b1;
        dec_o.imm_type = IMM_R;
        case (opcode)
            OPC_OP: begin
                dec_o.imm_type = IMM_R;
                dec_o.alu_opt  = alu_code(ir_i[30], funct3);
            end
            OPC_OP_IMM: begin
                dec_o.imm_type = IMM_I;
                // Only shift-right immediates carry the SRL/SRA select in bit 30;
                // for the others that bit is immediate data.
                dec_o.alu_opt  = alu_code((funct3 == 3'b101) ? ir_i[30] : 1'b0, funct3);
            end
            OPC_LOAD: begin
                dec_o.imm_type = IMM_I;
                dec_o.is_load  = 1'b1;
            end
            OPC_STORE: begin
                dec_o.imm_type = IMM_S;
                dec_o.is_store = 1'b1;
                dec_o.has_rd   = 1'b0;
            end
            OPC_BRANCH: begin
                dec_o.imm_type = IMM_B;
                dec_o.has_rd   = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: dec_o.imm_type = IMM_U;
            OPC_JAL:            dec_o.imm_type = IMM_J;
            OPC_JALR:           dec_o.imm_type = IMM_I;
            default: begin
                dec_o.legal  = 1'b0;
                dec_o.has_rd = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// cu_fsm: multi-cycle control unit FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK.
//   CLK, RST                     - clock, synchronous active-high reset
//   MEM_INST, INST_VALID, STALL  - instruction fetch interface
//   MEM_READY                    - data memory acknowledge
//   INST_REQ                     - fetch request (FETCH, not stalled)
//   RS1_ADR, RS2_ADR, REG_ADR    - registered register addresses
//   ALU_OPT, BR_OPT, LSU_OPT, IMM_TYPE - registered decoded controls
//   WRITE_ENB, MEM_WRITE_ENB, MEM_READ_ENB, PC_EN - registered strobes
//   STATE                        - current state
//   ILLEGAL, BUS_ERR             - sticky trap causes
module cu_fsm
    import cu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_ADR_W    = 5,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [XLEN-1:0]      MEM_INST,
    input  logic                 INST_VALID,
    input  logic                 MEM_READY,
    input  logic                 STALL,
    output logic                 INST_REQ,
    output logic [REG_ADR_W-1:0] RS1_ADR,
    output logic [REG_ADR_W-1:0] RS2_ADR,
    output logic [REG_ADR_W-1:0] REG_ADR,
    output logic [3:0]           ALU_OPT,
    output logic [2:0]           BR_OPT,
    output logic [2:0]           LSU_OPT,
    output logic [2:0]           IMM_TYPE,
    output logic                 WRITE_ENB,
    output logic                 MEM_WRITE_ENB,
    output logic                 MEM_READ_ENB,
    output logic                 PC_EN,
    output logic [2:0]           STATE,
    output logic                 ILLEGAL,
    output logic                 BUS_ERR
);

    localparam int              CNT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            ir_q;
    logic                   run_q;
    logic [REG_ADR_W-1:0]   rs1_q, rs2_q, rd_q;
    logic [3:0]             alu_q;
    logic [2:0]             f3_q, imm_q;
    logic                   is_load_q, is_store_q, has_rd_q;
    logic                   we_q, we_d;
    logic                   mwe_q, mwe_d;
    logic                   mre_q, mre_d;
    logic                   pc_en_q, pc_en_d;
    logic                   illegal_q, illegal_d;
    logic                   bus_err_q, bus_err_d;
    logic                   inst_req;
    logic                   accept;
    dec_t                   dec;

    if (XLEN > 32) begin : g_wide_inst
        logic unused_inst_hi;
        assign unused_inst_hi = ^MEM_INST[XLEN-1:32];
    end

    cu_decode u_decode (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    // run_q holds fetch off for the cycle in which reset is released.
    assign inst_req = run_q && (state_q == ST_FETCH) && !STALL;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_FETCH: begin
                if (inst_req && INST_VALID) begin
                    accept  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec.legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                cnt_d   = '0;
                state_d = (is_load_q || is_store_q) ? ST_MEM : ST_WRITEBACK;
            end
            ST_MEM: begin
                if (MEM_READY) begin
                    state_d = ST_WRITEBACK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase

        // Strobes are registered from the next state so they are high
        // exactly while the FSM sits in the corresponding state.
        mre_d   = (state_d == ST_MEM) && is_load_q;
        mwe_d   = (state_d == ST_MEM) && is_store_q;
        pc_en_d = (state_d == ST_WRITEBACK);
        we_d    = (state_d == ST_WRITEBACK) && has_rd_q && (rd_q != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_FETCH;
            cnt_q      <= '0;
            ir_q       <= '0;
            run_q      <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            f3_q       <= '0;
            imm_q      <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            has_rd_q   <= 1'b0;
            we_q       <= 1'b0;
            mwe_q      <= 1'b0;
            mre_q      <= 1'b0;
            pc_en_q    <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_q     <= 1'b1;
            we_q      <= we_d;
            mwe_q     <= mwe_d;
            mre_q     <= mre_d;
            pc_en_q   <= pc_en_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (accept) begin
                ir_q <= MEM_INST[31:0];
            end
            if (state_q == ST_DECODE) begin
                rs1_q      <= REG_ADR_W'(dec.rs1);
                rs2_q      <= REG_ADR_W'(dec.rs2);
                rd_q       <= REG_ADR_W'(dec.rd);
                alu_q      <= dec.alu_opt;
                f3_q       <= dec.funct3;
                imm_q      <= dec.imm_type;
                is_load_q  <= dec.is_load;
                is_store_q <= dec.is_store;
                has_rd_q   <= dec.has_rd;
            end
        end
    end

    assign INST_REQ      = inst_req;
    assign RS1_ADR       = rs1_q;
    assign RS2_ADR       = rs2_q;
    assign REG_ADR       = rd_q;
    assign ALU_OPT       = alu_q;
    assign BR_OPT        = f3_q;
    assign LSU_OPT       = f3_q;
    assign IMM_TYPE      = imm_q;
    assign WRITE_ENB     = we_q;
    assign MEM_WRITE_ENB = mwe_q;
    assign MEM_READ_ENB  = mre_q;
    assign PC_EN         = pc_en_q;
    assign STATE         = state_q;
    assign ILLEGAL       = illegal_q;
    assign BUS_ERR       = bus_err_q;

endmodule
